keccak_chi_iota_inv: RTL and testbench
======================================

Name: keccak_chi_iota_inv

Overview:
- Inverse of the Keccak-200 chi+iota layer, used on the decryption/inverse-permutation datapath and as a self-check of the forward layer.
- Accepts a full 25*W-bit state plus the round constant over a valid/ready handshake.
- Strips iota, then applies chi^-1 slice-serially: one z-slice, 5 rows, per cycle.
- Returns the recovered state over a valid/ready handshake with backpressure.

Parameters:
- W, 8, lane width in bits (8 for Keccak-200); state is 25*W bits.

Ports:
- ClkxCI  in  1  clock; all state changes on the rising edge.
- RstxRBI  in  1  asynchronous, active-low reset.
- InValidxSI  in  1  input state and constant are valid.
- InReadyxSO  out  1  block can accept a new state.
- StatexDI  in  25*W  chi+iota output state to invert.
- IotaRCxDI  in  W  round constant used by the forward iota.
- OutValidxSO  out  1  inverted state is available.
- OutReadyxSI  in  1  consumer takes the output.
- StatexDO  out  25*W  recovered chi input state.

Behaviour:
- Lane layout:
  - Lane (x,y) occupies bits [(5x+y)*W +: W].
  - Row (y,z) is the 5 bits x=0..4 at offset (5x+y)*W+z, with x=0 as the LSB of the row.
- Forward relation being inverted:
  - Chi: b_x = a_x ^ (~a_{x+1} & a_{x+2}), indices mod 5.
  - Iota: XORs the constant, zero-extended, into lane (0,0), i.e. bits [W-1:0] only.
- FSM states: IDLE, RUN, DONE.
- Reset (asynchronous, RstxRBI=0), effective immediately even mid-RUN or mid-DONE:
  - FSM goes to IDLE; slice counter = 0; state register = 0.
  - Outputs: InReadyxSO=1, OutValidxSO=0, StatexDO=0.
- IDLE:
  - InReadyxSO=1.
  - On InValidxSI=1, load StatexDI with bits [W-1:0] XORed with IotaRCxDI; all other bits load unchanged. This removes iota.
  - Set counter to 0 and go to RUN.
- RUN:
  - InReadyxSO=0.
  - Each cycle, replace the 5 rows of slice z=counter in the state register with chi^-1 of each row.
  - Counter increments each cycle. When counter = W-1, that slice is processed and the FSM goes to DONE.
  - Handshake inputs are ignored.
- DONE:
  - OutValidxSO=1; StatexDO = state register.
  - Held stable until OutReadyxSI=1, then go to IDLE.
  - InReadyxSO=0 in DONE. No bypass from output to a same-cycle new input.
- Latency:
  - Accept edge at cycle 0; OutValidxSO rises after the edge at cycle W (W RUN cycles).
  - Minimum initiation interval is W+2 cycles.
- StatexDO is registered and driven from the state register; its value is only meaningful while OutValidxSO=1.
- Chi^-1 per row is purely combinational (a 32-entry bijection) and the exact inverse of the forward chi row map.
  - Anchor values: chi^-1(0x00)=0x00, chi^-1(0x09)=0x01, chi^-1(0x1F)=0x1F.
- Counter width is clog2(W); the wrap at W-1 is exclusive of the DONE transition, so no extra slice is processed.
- If InValidxSI stays high after acceptance, nothing is captured until the next IDLE.

Decomposition:
- Shared package holds:
  - Keccak-200 constants: W, state width 25*W, number of rows 5.
  - The lane/row index function (5x+y)*W.
  - FSM state encoding.
- One natural sub-module: keccak_sbox_inv.
  - Ports aa..ee in, ap..ep out, mirroring the forward sbox.
  - Instantiated 5 times, one per row y of the current slice.
  - Slice selection/write-back is done by the counter-driven mux in the top module.

Test Plan:
- Reset mid-RUN: assert RstxRBI low during RUN, release -> same cycle InReadyxSO=1, OutValidxSO=0, StatexDO=0; the next accepted state is processed normally.
- Every row equal to 0x09 (bits x=0 and x=3 set in all 5*W rows), IotaRCxDI=0 -> after W+1 cycles every row is 0x01, i.e. lanes x=0 = 0xFF and all other lanes 0x00.
- All-ones state, IotaRCxDI=0x00 -> output all-ones (chi^-1(0x1F)=0x1F); with IotaRCxDI=0xFF -> lane (0,0) is inverted before chi^-1, and the result matches the golden model.
- Round trip: 1000 random states S and constants RC, feed chi+iota(S, RC) in -> StatexDO == S every time.
- Backpressure: hold OutReadyxSI=0 for 5 cycles in DONE -> StatexDO stable, OutValidxSO=1, InReadyxSO=0, a pending InValidxSI not accepted; after release, back to IDLE the next cycle.
- Back-to-back: InValidxSI held high with two different states -> the second is accepted only after the first output handshake; both results are correct and in order.

Source files
------------

// File: rtl/keccak_chi_iota_inv_pkg.sv
// Shared Keccak-200 constants, lane/row indexing, FSM encoding and the forward chi row map.
// Pure declarations; no timing or handshake behaviour.
package keccak_chi_iota_inv_pkg;

    localparam int KW       = 8;
    localparam int KSTATE_W = 25 * KW;
    localparam int NROWS    = 5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Bit offset of lane (x,y); row (y,z) bit x lives at lane_base(x,y,w)+z.
    function automatic int lane_base(input int x, input int y, input int w);
        return (5 * x + y) * w;
    endfunction

    function automatic logic [4:0] chi_row(input logic [4:0] a);
        logic [4:0] b;
        b = '0;
        for (int x = 0; x < 5; x++) begin
            b[x] = a[x] ^ (~a[(x + 1) % 5] & a[(x + 2) % 5]);
        end
        return b;
    endfunction

endpackage

// File: rtl/keccak_sbox_inv.sv
// Inverse of the 5-bit Keccak chi row map; combinational, zero latency.
// No handshake: a pure function of its inputs.
import keccak_chi_iota_inv_pkg::*;

module keccak_sbox_inv (
    input  logic aa,
    input  logic bb,
    input  logic cc,
    input  logic dd,
    input  logic ee,
    output logic ap,
    output logic bp,
    output logic cp,
    output logic dp,
    output logic ep
);

    logic [4:0] row_b;
    logic [4:0] row_a;

    assign row_b = {ee, dd, cc, bb, aa};

    // chi is a bijection on 5 bits, so exactly one preimage matches.
    always_comb begin
        row_a = '0;
        for (int i = 0; i < 32; i++) begin
            if (chi_row(5'(i)) == row_b) begin
                row_a = 5'(i);
            end
        end
    end

    assign {ep, dp, cp, bp, ap} = row_a;

endmodule

// File: rtl/keccak_chi_iota_inv.sv
// Inverts Keccak-200 chi+iota one z-slice per cycle; output valid W cycles after accept.
// Result held in DONE until OutReadyxSI; no input accepted until back in IDLE.
import keccak_chi_iota_inv_pkg::*;

module keccak_chi_iota_inv #(
    parameter int W = KW
) (
    input  logic              ClkxCI,
    input  logic              RstxRBI,
    input  logic              InValidxSI,
    output logic              InReadyxSO,
    input  logic [25*W-1:0]   StatexDI,
    input  logic [W-1:0]      IotaRCxDI,
    output logic              OutValidxSO,
    input  logic              OutReadyxSI,
    output logic [25*W-1:0]   StatexDO
);

    localparam int STATE_W = 25 * W;
    localparam int CNT_W   = (W > 1) ? $clog2(W) : 1;
    localparam int IDX_W   = $clog2(STATE_W);

    logic [1:0]               fsm_q;
    logic [CNT_W-1:0]         cnt_q;
    logic [STATE_W-1:0]       st_q;
    logic [NROWS-1:0][4:0]    row_cur;
    logic [NROWS-1:0][4:0]    row_new;

    function automatic logic [IDX_W-1:0] slice_idx(input int x, input int y,
                                                   input logic [CNT_W-1:0] z);
        return IDX_W'(lane_base(x, y, W)) + IDX_W'(z);
    endfunction

    always_comb begin
        row_cur = '0;
        for (int y = 0; y < NROWS; y++) begin
            for (int x = 0; x < 5; x++) begin
                row_cur[y][x] = st_q[slice_idx(x, y, cnt_q)];
            end
        end
    end

    for (genvar y = 0; y < NROWS; y++) begin : g_row
        keccak_sbox_inv u_sbox (
            .aa(row_cur[y][0]),
            .bb(row_cur[y][1]),
            .cc(row_cur[y][2]),
            .dd(row_cur[y][3]),
            .ee(row_cur[y][4]),
            .ap(row_new[y][0]),
            .bp(row_new[y][1]),
            .cp(row_new[y][2]),
            .dp(row_new[y][3]),
            .ep(row_new[y][4])
        );
    end

    always_ff @(posedge ClkxCI or negedge RstxRBI) begin
        if (!RstxRBI) begin
            fsm_q <= ST_IDLE;
            cnt_q <= '0;
            st_q  <= '0;
        end else begin
            case (fsm_q)
                ST_IDLE: begin
                    if (InValidxSI) begin
                        // Iota only touched lane (0,0), so undo it on load.
                        st_q  <= StatexDI ^ {{(STATE_W - W){1'b0}}, IotaRCxDI};
                        cnt_q <= '0;
                        fsm_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    for (int y = 0; y < NROWS; y++) begin
                        for (int x = 0; x < 5; x++) begin
                            st_q[slice_idx(x, y, cnt_q)] <= row_new[y][x];
                        end
                    end
                    if (cnt_q == CNT_W'(W - 1)) begin
                        cnt_q <= '0;
                        fsm_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (OutReadyxSI) begin
                        fsm_q <= ST_IDLE;
                    end
                end
                default: fsm_q <= ST_IDLE;
            endcase
        end
    end

    assign InReadyxSO  = (fsm_q == ST_IDLE);
    assign OutValidxSO = (fsm_q == ST_DONE);
    assign StatexDO    = st_q;

endmodule

// File: tb/tb_keccak_chi_iota_inv.sv
// Directed and round-trip checks of the chi+iota inverse against an independent forward model.
module tb_keccak_chi_iota_inv;

    localparam int W  = 8;
    localparam int SW = 25 * W;

    logic          clk;
    logic          rst_n;
    logic          in_vld;
    logic          in_rdy;
    logic [SW-1:0] st_in;
    logic [W-1:0]  rc_in;
    logic          out_vld;
    logic          out_rdy;
    logic [SW-1:0] st_out;

    int checks;
    int errors;
    logic [4:0] inv_tab [32];

    keccak_chi_iota_inv #(.W(W)) dut (
        .ClkxCI     (clk),
        .RstxRBI    (rst_n),
        .InValidxSI (in_vld),
        .InReadyxSO (in_rdy),
        .StatexDI   (st_in),
        .IotaRCxDI  (rc_in),
        .OutValidxSO(out_vld),
        .OutReadyxSI(out_rdy),
        .StatexDO   (st_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] m_chi(input logic [4:0] a);
        logic [4:0] b;
        b[0] = a[0] ^ (~a[1] & a[2]);
        b[1] = a[1] ^ (~a[2] & a[3]);
        b[2] = a[2] ^ (~a[3] & a[4]);
        b[3] = a[3] ^ (~a[4] & a[0]);
        b[4] = a[4] ^ (~a[0] & a[1]);
        return b;
    endfunction

    function automatic logic [SW-1:0] m_fwd(input logic [SW-1:0] s, input logic [W-1:0] rc);
        logic [SW-1:0] r;
        logic [4:0] row;
        r = s;
        for (int y = 0; y < 5; y++)
            for (int z = 0; z < W; z++) begin
                for (int x = 0; x < 5; x++) row[x] = s[(5*x+y)*W+z];
                row = m_chi(row);
                for (int x = 0; x < 5; x++) r[(5*x+y)*W+z] = row[x];
            end
        r[W-1:0] = r[W-1:0] ^ rc;
        return r;
    endfunction

    function automatic logic [SW-1:0] m_inv(input logic [SW-1:0] s, input logic [W-1:0] rc);
        logic [SW-1:0] t;
        logic [SW-1:0] r;
        logic [4:0] row;
        t = s;
        t[W-1:0] = t[W-1:0] ^ rc;
        r = t;
        for (int y = 0; y < 5; y++)
            for (int z = 0; z < W; z++) begin
                for (int x = 0; x < 5; x++) row[x] = t[(5*x+y)*W+z];
                row = inv_tab[row];
                for (int x = 0; x < 5; x++) r[(5*x+y)*W+z] = row[x];
            end
        return r;
    endfunction

    function automatic logic [SW-1:0] rand_state();
        logic [223:0] t;
        for (int i = 0; i < 7; i++) t[i*32 +: 32] = $urandom;
        return t[SW-1:0];
    endfunction

    function automatic logic [SW-1:0] lanes_x(input logic [4:0] xmask);
        logic [SW-1:0] r;
        r = '0;
        for (int x = 0; x < 5; x++)
            if (xmask[x])
                for (int y = 0; y < 5; y++) r[(5*x+y)*W +: W] = {W{1'b1}};
        return r;
    endfunction

    // One transaction; lat = cycles from accept edge to OutValid, -1 on timeout.
    task automatic xact(input logic [SW-1:0] s, input logic [W-1:0] rc,
                        output logic [SW-1:0] res, output int lat);
        int n;
        @(posedge clk); #1;
        in_vld = 1'b1; st_in = s; rc_in = rc;
        n = 0;
        while (!in_rdy && n < 100) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        in_vld = 1'b0;
        lat = 0;
        while (!out_vld && lat < 100) begin @(posedge clk); #1; lat++; end
        if (lat >= 100) lat = -1;
        res = st_out;
        out_rdy = 1'b1;
        @(posedge clk); #1;
        out_rdy = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_rdy !== 1'b1 || out_vld !== 1'b0 || st_out !== '0) begin
            errors++;
            $display("FAIL reset: rdy=%b vld=%b st=%h, required rdy=1 vld=0 st=0", in_rdy, out_vld, st_out);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_anchor_rows();
        logic [SW-1:0] res;
        int lat;
        xact(lanes_x(5'b01001), '0, res, lat);
        checks++;
        if (lat !== W) begin
            errors++;
            $display("FAIL latency: got %0d, required %0d", lat, W);
        end
        checks++;
        if (res !== lanes_x(5'b00001)) begin
            errors++;
            $display("FAIL rows_09: got %h, required %h", res, lanes_x(5'b00001));
        end
        xact('0, '0, res, lat);
        checks++;
        if (res !== '0 || lat !== W) begin
            errors++;
            $display("FAIL all_zero: got %h lat %0d, required 0 lat %0d", res, lat, W);
        end
    endtask

    task automatic test_all_ones();
        logic [SW-1:0] res;
        logic [SW-1:0] exp;
        int lat;
        xact({SW{1'b1}}, 8'h00, res, lat);
        checks++;
        if (res !== {SW{1'b1}}) begin
            errors++;
            $display("FAIL all_ones_rc0: got %h, required all ones", res);
        end
        xact({SW{1'b1}}, 8'hFF, res, lat);
        exp = m_inv({SW{1'b1}}, 8'hFF);
        checks++;
        if (res !== exp) begin
            errors++;
            $display("FAIL all_ones_rcff: got %h, required %h", res, exp);
        end
        checks++;
        if (m_fwd(res, 8'hFF) !== {SW{1'b1}}) begin
            errors++;
            $display("FAIL all_ones_rcff_fwd: got %h, required all ones", m_fwd(res, 8'hFF));
        end
    endtask

    task automatic test_round_trip();
        logic [SW-1:0] s;
        logic [SW-1:0] res;
        logic [W-1:0] rc;
        int lat;
        for (int i = 0; i < 1000; i++) begin
            s = rand_state();
            rc = W'($urandom);
            xact(m_fwd(s, rc), rc, res, lat);
            checks++;
            if (res !== s || lat !== W) begin
                errors++;
                $display("FAIL round_trip[%0d]: got %h lat %0d, required %h lat %0d", i, res, lat, s, W);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        logic [SW-1:0] s;
        logic [SW-1:0] res;
        int lat;
        @(posedge clk); #1;
        in_vld = 1'b1; st_in = rand_state(); rc_in = 8'h5A;
        @(posedge clk); #1;
        in_vld = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (in_rdy !== 1'b1 || out_vld !== 1'b0 || st_out !== '0) begin
            errors++;
            $display("FAIL reset_mid_run: rdy=%b vld=%b st=%h, required 1 0 0", in_rdy, out_vld, st_out);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        s = rand_state();
        xact(m_fwd(s, 8'h81), 8'h81, res, lat);
        checks++;
        if (res !== s || lat !== W) begin
            errors++;
            $display("FAIL after_reset: got %h lat %0d, required %h lat %0d", res, lat, s, W);
        end
    endtask

    task automatic test_backpressure();
        logic [SW-1:0] s;
        logic [SW-1:0] held;
        int n;
        s = rand_state();
        @(posedge clk); #1;
        in_vld = 1'b1; st_in = m_fwd(s, 8'h33); rc_in = 8'h33;
        @(posedge clk); #1;
        in_vld = 1'b0;
        n = 0;
        while (!out_vld && n < 100) begin @(posedge clk); #1; n++; end
        checks++;
        if (st_out !== s || n !== W) begin
            errors++;
            $display("FAIL bp_result: got %h after %0d, required %h after %0d", st_out, n, s, W);
        end
        held = st_out;
        in_vld = 1'b1; st_in = rand_state(); rc_in = 8'h01;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++;
            if (st_out !== held || out_vld !== 1'b1 || in_rdy !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: st=%h vld=%b rdy=%b, required %h 1 0", c, st_out, out_vld, in_rdy, held);
            end
        end
        in_vld = 1'b0;
        out_rdy = 1'b1;
        @(posedge clk); #1;
        out_rdy = 1'b0;
        checks++;
        if (out_vld !== 1'b0 || in_rdy !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: vld=%b rdy=%b, required 0 1", out_vld, in_rdy);
        end
    endtask

    task automatic test_back_to_back();
        logic [SW-1:0] a1;
        logic [SW-1:0] a2;
        int n;
        a1 = rand_state();
        a2 = rand_state();
        @(posedge clk); #1;
        in_vld = 1'b1; st_in = m_fwd(a1, 8'h11); rc_in = 8'h11;
        @(posedge clk); #1;
        st_in = m_fwd(a2, 8'hE4); rc_in = 8'hE4;
        n = 0;
        while (!out_vld && n < 100) begin @(posedge clk); #1; n++; end
        checks++;
        if (st_out !== a1 || in_rdy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first: got %h rdy=%b, required %h rdy=0", st_out, in_rdy, a1);
        end
        out_rdy = 1'b1;
        @(posedge clk); #1;
        out_rdy = 1'b0;
        @(posedge clk); #1;
        in_vld = 1'b0;
        checks++;
        if (in_rdy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept2: rdy=%b, required 0", in_rdy);
        end
        n = 0;
        while (!out_vld && n < 100) begin @(posedge clk); #1; n++; end
        checks++;
        if (st_out !== a2 || n !== W) begin
            errors++;
            $display("FAIL b2b_second: got %h after %0d, required %h after %0d", st_out, n, a2, W);
        end
        out_rdy = 1'b1;
        @(posedge clk); #1;
        out_rdy = 1'b0;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        in_vld  = 1'b0;
        out_rdy = 1'b0;
        st_in   = '0;
        rc_in   = '0;
        rst_n   = 1'b1;
        for (int v = 0; v < 32; v++) inv_tab[m_chi(5'(v))] = 5'(v);
        test_reset();
        test_anchor_rows();
        test_all_ones();
        test_reset_mid_run();
        test_backpressure();
        test_back_to_back();
        test_round_trip();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
